fifo_stream_reader: RTL

//  Read-side stage downstream of the synchronous FIFO controller/memory. Drives the FIFO rd strobe,

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_out_buf2.sv | 63 ++++++
 rtl/fifo_stream_reader.sv | 56 +++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO read-path constants and types
package fifo_pkg;

    // Words the stream reader can hold between the FIFO and the consumer.
    localparam int OUT_BUF_DEPTH = 2;

    // Occupancy of the output buffer, 0..OUT_BUF_DEPTH.
    typedef logic [1:0] buf_level_t;

endpackage

// File: rtl/fifo_out_buf2.sv
// rtl/fifo_out_buf2.sv - two-entry shift buffer feeding the output stream
module fifo_out_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output buf_level_t            occ,
    output logic                  valid
);

    logic [DATA_WIDTH-1:0] entry1;
    buf_level_t            occ_next;

    // Occupancy after this cycle's pop and push; a simultaneous pop and push cancel out.
    always_comb begin
        occ_next = occ;
        case ({pop, push})
            2'b01:   occ_next = occ + 2'd1;
            2'b10:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    // Shift storage: pops move entry1 into the head, pushes land in the first free slot after the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            head   <= '0;
            entry1 <= '0;
            occ    <= '0;
            valid  <= 1'b0;
        end else if (flush) begin
            occ   <= '0;
            valid <= 1'b0;
        end else begin
            occ   <= occ_next;
            valid <= (occ_next != 2'd0);
            case ({pop, push})
                2'b01: begin
                    if (occ == 2'd0) head <= push_data;
                    else             entry1 <= push_data;
                end
                2'b10: head <= entry1;
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head   <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read strobe generation and valid/ready output stream
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            level
);

    logic       inflight;
    logic       pop;
    buf_level_t occ;
    logic [2:0] credit_sum;

    assign pop = m_valid & m_ready;

    // Words already owned by the buffer once this cycle settles; a read is only
    // issued if its data is guaranteed a free slot when it arrives next cycle.
    assign credit_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd    = ~reset & ~flush & ~fifo_empty & (credit_sum < 3'(OUT_BUF_DEPTH));

    // The FIFO returns data one cycle after the strobe; remember that a word is on its way.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd;
        end
    end

    fifo_out_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (inflight),
        .push_data(fifo_rdata),
        .pop      (pop),
        .head     (m_data),
        .occ      (occ),
        .valid    (m_valid)
    );

    assign level = occ;

endmodule
